// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic light request conditioner.
// Light encodings, direction indices and the emergency arbiter state type.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b100;

  localparam int DIR_N = 0;
  localparam int DIR_S = 1;
  localparam int DIR_E = 2;
  localparam int DIR_W = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  // Isolates the lowest set bit, which gives N the highest priority.
  function automatic logic [3:0] lowest_onehot(input logic [3:0] req);
    lowest_onehot = req & (~req + 4'd1);
  endfunction

endpackage

// File: rtl/traffic_request_conditioner_sync_debounce.sv
// Single-bit synchroniser followed by a counting debouncer.
// The filtered level flips only after DEBOUNCE_CYCLES consecutive differing samples.
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_an,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   sample;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign sample = sync_q[SYNC_STAGES-1];

  // Any matching sample restarts the stability count from zero.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sample != level_q) begin
      if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sample;
        rise_d  = sample;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/traffic_request_conditioner.sv
// Conditions raw pedestrian and emergency inputs for the 4-way light controller:
// debounced pedestrian latch with wait counter, plus a non-preemptive emergency arbiter.
module traffic_request_conditioner
  import traffic_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WAIT_W          = 8
) (
  input  logic              clk,
  input  logic              rst_an,
  input  logic              ped_button_raw,
  input  logic [3:0]        emergency_raw,
  input  logic [2:0]        n_lights,
  input  logic [2:0]        s_lights,
  input  logic [2:0]        e_lights,
  input  logic [2:0]        w_lights,
  output logic              ped_request,
  output logic [3:0]        emergency_dir,
  output logic              emergency_active,
  output logic [WAIT_W-1:0] ped_wait
);

  logic              ped_rise;
  logic              ped_level_unused;
  logic [3:0]        emg_filt;
  logic [3:0]        emg_rise_unused;
  logic              all_red;
  logic              ped_q, ped_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  arb_state_e        state_q, state_d;
  logic [3:0]        dir_q, dir_d;
  logic              active_q;

  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ped_filter (
    .clk    (clk),
    .rst_an (rst_an),
    .raw_i  (ped_button_raw),
    .level_o(ped_level_unused),
    .rise_o (ped_rise)
  );

  for (genvar i = DIR_N; i <= DIR_W; i++) begin : g_emg_filter
    sync_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
      .clk    (clk),
      .rst_an (rst_an),
      .raw_i  (emergency_raw[i]),
      .level_o(emg_filt[i]),
      .rise_o (emg_rise_unused[i])
    );
  end

  assign all_red = (n_lights == LIGHT_RED) && (s_lights == LIGHT_RED) &&
                   (e_lights == LIGHT_RED) && (w_lights == LIGHT_RED);

  // A press seen during all-red is dropped: pedestrians are already crossing.
  always_comb begin
    ped_d = ped_q;
    if (all_red && ped_q) begin
      ped_d = 1'b0;
    end else if (ped_rise && !all_red) begin
      ped_d = 1'b1;
    end
    wait_d = '0;
    if (ped_q && ped_d) begin
      wait_d = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      ARB_IDLE: begin
        dir_d = '0;
        if (|emg_filt) begin
          dir_d   = lowest_onehot(emg_filt);
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if ((emg_filt & dir_q) == 4'b0000) begin
          dir_d   = '0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        dir_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      ped_q    <= 1'b0;
      wait_q   <= '0;
      state_q  <= ARB_IDLE;
      dir_q    <= '0;
      active_q <= 1'b0;
    end else begin
      ped_q    <= ped_d;
      wait_q   <= wait_d;
      state_q  <= state_d;
      dir_q    <= dir_d;
      active_q <= |dir_d;
    end
  end

  assign ped_request      = ped_q;
  assign ped_wait         = wait_q;
  assign emergency_dir    = dir_q;
  assign emergency_active = active_q;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Scoreboard bench for traffic_request_conditioner: expected per-edge outputs are
// queued when stimulus is applied and popped as each clock edge completes.
module tb_traffic_request_conditioner;

  localparam logic [2:0] RED   = 3'b001;
  localparam logic [2:0] GREEN = 3'b100;

  typedef struct {
    logic [13:0] v;
    string       tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_an;
  logic       ped_raw;
  logic [3:0] emg_raw;
  logic [2:0] n_l, s_l, e_l, w_l;

  logic       ped_request, emergency_active;
  logic [3:0] emergency_dir;
  logic [7:0] ped_wait;
  logic       ped4, act4;
  logic [3:0] dir4;
  logic [3:0] wait4;

  exp_t        sb[$];
  logic [9:0]  sb4[$];
  int          tests = 0;
  int          fails = 0;

  traffic_request_conditioner dut (
    .clk             (clk),
    .rst_an          (rst_an),
    .ped_button_raw  (ped_raw),
    .emergency_raw   (emg_raw),
    .n_lights        (n_l),
    .s_lights        (s_l),
    .e_lights        (e_l),
    .w_lights        (w_l),
    .ped_request     (ped_request),
    .emergency_dir   (emergency_dir),
    .emergency_active(emergency_active),
    .ped_wait        (ped_wait)
  );

  traffic_request_conditioner #(.WAIT_W(4)) dut_w4 (
    .clk             (clk),
    .rst_an          (rst_an),
    .ped_button_raw  (ped_raw),
    .emergency_raw   (emg_raw),
    .n_lights        (n_l),
    .s_lights        (s_l),
    .e_lights        (e_l),
    .w_lights        (w_l),
    .ped_request     (ped4),
    .emergency_dir   (dir4),
    .emergency_active(act4),
    .ped_wait        (wait4)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] obs();
    return {ped_request, emergency_dir, emergency_active, ped_wait};
  endfunction

  function automatic logic [9:0] obs4();
    return {ped4, dir4, act4, wait4};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lights(input logic [2:0] n, input logic [2:0] s,
                            input logic [2:0] e, input logic [2:0] w);
    n_l = n; s_l = s; e_l = e; w_l = w;
  endtask

  task automatic push(input logic p, input logic [3:0] d, input logic [7:0] w, input string tag);
    exp_t e;
    e.v   = {p, d, |d, w};
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_an  = 1'b0;
    ped_raw = 1'b0;
    emg_raw = 4'b0000;
    set_lights(GREEN, RED, GREEN, RED);
    repeat (3) tick();
    tests++;
    if (obs() !== 14'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected %h", obs(), 14'h0);
    end
    tests++;
    if (obs4() !== 10'h0) begin
      fails++;
      $display("FAIL reset_outputs_w4: got %h expected %h", obs4(), 10'h0);
    end
    rst_an = 1'b1;
  endtask

  task automatic test_ped_latch();
    exp_t e;
    set_lights(GREEN, GREEN, RED, RED);
    ped_raw = 1'b1;
    for (int k = 1; k <= 20; k++) push(k >= 7, 4'b0000, (k >= 8) ? 8'(k - 7) : 8'd0, "ped_latch");
    for (int k = 1; k <= 20; k++) begin
      tick();
      e = sb.pop_front();
      tests++;
      if (obs() !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %h expected %h", e.tag, k, obs(), e.v);
      end
    end
    set_lights(RED, RED, RED, RED);
    push(1'b0, 4'b0000, 8'd0, "ped_clear_all_red");
    for (int k = 1; k <= 1; k++) push(1'b0, 4'b0000, 8'd0, "ped_after_clear");
    for (int k = 1; k <= 2; k++) begin
      tick();
      e = sb.pop_front();
      tests++;
      if (obs() !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %h expected %h", e.tag, k, obs(), e.v);
      end
    end
    ped_raw = 1'b0;
    set_lights(GREEN, RED, GREEN, RED);
    for (int k = 1; k <= 10; k++) push(1'b0, 4'b0000, 8'd0, "ped_release");
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = sb.pop_front();
      tests++;
      if (obs() !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %h expected %h", e.tag, k, obs(), e.v);
      end
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    logic pattern [19];
    for (int k = 0; k < 19; k++) pattern[k] = 1'b0;
    pattern[0] = 1'b1; pattern[1] = 1'b1; pattern[2] = 1'b1;
    pattern[4] = 1'b1; pattern[5] = 1'b1;
    for (int k = 0; k < 19; k++) push(1'b0, 4'b0000, 8'd0, "bounce");
    for (int k = 0; k < 19; k++) begin
      ped_raw = pattern[k];
      tick();
      e = sb.pop_front();
      tests++;
      if (obs() !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %h expected %h", e.tag, k + 1, obs(), e.v);
      end
    end
  endtask

  task automatic test_ped_all_red();
    exp_t e;
    set_lights(RED, RED, RED, RED);
    ped_raw = 1'b1;
    for (int k = 1; k <= 12; k++) push(1'b0, 4'b0000, 8'd0, "press_all_red");
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = sb.pop_front();
      tests++;
      if (obs() !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %h expected %h", e.tag, k, obs(), e.v);
      end
    end
    ped_raw = 1'b0;
    for (int k = 1; k <= 12; k++) push(1'b0, 4'b0000, 8'd0, "release_all_red");
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = sb.pop_front();
      tests++;
      if (obs() !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %h expected %h", e.tag, k, obs(), e.v);
      end
    end
    set_lights(GREEN, RED, RED, RED);
    ped_raw = 1'b1;
    for (int k = 1; k <= 10; k++) push(k >= 7, 4'b0000, (k >= 8) ? 8'(k - 7) : 8'd0, "press_n_green");
    set_lights(GREEN, RED, RED, RED);
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = sb.pop_front();
      tests++;
      if (obs() !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %h expected %h", e.tag, k, obs(), e.v);
      end
    end
    set_lights(RED, RED, RED, RED);
    ped_raw = 1'b0;
    for (int k = 1; k <= 9; k++) push(1'b0, 4'b0000, 8'd0, "serve_n_green");
    for (int k = 1; k <= 9; k++) begin
      tick();
      e = sb.pop_front();
      tests++;
      if (obs() !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %h expected %h", e.tag, k, obs(), e.v);
      end
    end
  endtask

  task automatic test_emergency();
    exp_t e;
    set_lights(GREEN, GREEN, RED, RED);
    ped_raw = 1'b0;
    emg_raw = 4'b0110;
    for (int k = 1; k <= 10; k++) push(1'b0, (k >= 7) ? 4'b0010 : 4'b0000, 8'd0, "emg_grant_s");
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = sb.pop_front();
      tests++;
      if (obs() !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %h expected %h", e.tag, k, obs(), e.v);
      end
    end
    emg_raw = 4'b0111;
    for (int k = 1; k <= 10; k++) push(1'b0, 4'b0010, 8'd0, "emg_no_preempt");
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = sb.pop_front();
      tests++;
      if (obs() !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %h expected %h", e.tag, k, obs(), e.v);
      end
    end
    emg_raw = 4'b0101;
    for (int k = 1; k <= 12; k++)
      push(1'b0, (k <= 6) ? 4'b0010 : ((k == 7) ? 4'b0000 : 4'b0001), 8'd0, "emg_handover_n");
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = sb.pop_front();
      tests++;
      if (obs() !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %h expected %h", e.tag, k, obs(), e.v);
      end
    end
    emg_raw = 4'b0000;
    for (int k = 1; k <= 10; k++) push(1'b0, (k <= 6) ? 4'b0001 : 4'b0000, 8'd0, "emg_release");
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = sb.pop_front();
      tests++;
      if (obs() !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %h expected %h", e.tag, k, obs(), e.v);
      end
    end
  endtask

  task automatic test_wait_sat();
    exp_t       e;
    logic [9:0] e4;
    int         w;
    rst_an = 1'b0;
    tick();
    rst_an = 1'b1;
    set_lights(GREEN, RED, GREEN, RED);
    emg_raw = 4'b0000;
    ped_raw = 1'b1;
    for (int k = 1; k <= 280; k++) begin
      w = (k >= 8) ? k - 7 : 0;
      push(k >= 7, 4'b0000, (w > 255) ? 8'd255 : 8'(w), "wait_sat_w8");
      sb4.push_back({k >= 7, 4'b0000, 1'b0, (w > 15) ? 4'd15 : 4'(w)});
    end
    for (int k = 1; k <= 280; k++) begin
      tick();
      e  = sb.pop_front();
      e4 = sb4.pop_front();
      tests++;
      if (obs() !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %h expected %h", e.tag, k, obs(), e.v);
      end
      tests++;
      if (obs4() !== e4) begin
        fails++;
        $display("FAIL wait_sat_w4 edge %0d: got %h expected %h", k, obs4(), e4);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    rst_an = 1'b0;
    tick();
    rst_an = 1'b1;
    set_lights(GREEN, RED, GREEN, RED);
    ped_raw = 1'b1;
    emg_raw = 4'b0100;
    for (int k = 1; k <= 10; k++)
      push(k >= 7, (k >= 7) ? 4'b0100 : 4'b0000, (k >= 8) ? 8'(k - 7) : 8'd0, "pre_reset_grant_e");
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = sb.pop_front();
      tests++;
      if (obs() !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %h expected %h", e.tag, k, obs(), e.v);
      end
    end
    #2;
    rst_an = 1'b0;
    #1;
    tests++;
    if (obs() !== 14'h0) begin
      fails++;
      $display("FAIL async_reset_immediate: got %h expected %h", obs(), 14'h0);
    end
    tick();
    tick();
    tests++;
    if (obs() !== 14'h0) begin
      fails++;
      $display("FAIL async_reset_held: got %h expected %h", obs(), 14'h0);
    end
    rst_an = 1'b1;
    for (int k = 1; k <= 10; k++)
      push(k >= 7, (k >= 7) ? 4'b0100 : 4'b0000, (k >= 8) ? 8'(k - 7) : 8'd0, "post_reset_regrant_e");
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = sb.pop_front();
      tests++;
      if (obs() !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %h expected %h", e.tag, k, obs(), e.v);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ped_latch();
    test_bounce();
    test_ped_all_red();
    test_emergency();
    test_wait_sat();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
